mod_add_sub: RTL and testbench

//  - Pipelined modular adder/subtractor (a +/- b mod Q) for the NTT butterfly datapath.
//  - Sits directly downstream of the ripple-carry full-adder chain. It registers the raw W+1-bit sum or difference from that chain, then applies the conditional +/-Q correction.
//  - Output feeds the butterfly write-back stage.
//  - Uses a valid/ready stream on both sides.

---
 rtl/mod_arith_pkg.sv | 17 +
 rtl/Full_Adder.sv | 13 +
 rtl/rc_adder.sv | 27 ++
 rtl/mod_add_sub.sv | 114 +++++++++++
 tb/tb_mod_add_sub.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/mod_arith_pkg.sv
// Shared constants, op encoding and stage-1 record for the modular add/sub pipeline.
package mod_arith_pkg;

    localparam int W_DEF = 14;
    localparam int Q_DEF = 12289;
    localparam int TAG_W_DEF = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic                   op;
        logic [W_DEF:0]         raw;
        logic [TAG_W_DEF-1:0]   tag;
    } s1_rec_t;

endpackage

// File: rtl/Full_Adder.sv
// One-bit full adder cell used to build the ripple-carry chains.
module Full_Adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rc_adder.sv
// N-bit ripple-carry adder chained from Full_Adder cells.
module rc_adder #(
    parameter int N = 14
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] c;

    assign c[0] = cin;
    assign cout = c[N];

    for (genvar i = 0; i < N; i++) begin : g_fa
        Full_Adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .sum  (sum[i]),
            .cout (c[i+1])
        );
    end

endmodule

// File: rtl/mod_add_sub.sv
// Two-stage modular adder/subtractor (a +/- b mod Q) with valid/ready on both sides.
// Subtraction is built only when MOD_ADD_SUB_SUB_EN is defined; otherwise every op is ADD.
module mod_add_sub
    import mod_arith_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int Q     = Q_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_r,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [W-1:0] QV    = W'(Q);
    localparam logic [W-1:0] NEG_Q = W'(~QV + 1'b1);

    logic         s1_valid;
    s1_rec_t      s1;
    logic         s1_load;
    logic         s2_load;

    logic         op_sub;
    logic [W-1:0] b_eff;
    logic         cin1;
    logic [W-1:0] sum1;
    logic         cout1;

    logic [W-1:0] addend;
    logic [W-1:0] sum2;
    logic         cout2;
    logic         take;
    logic [W-1:0] r_next;

`ifdef MOD_ADD_SUB_SUB_EN
    assign op_sub = in_op;
    assign b_eff  = in_op ? ~in_b : in_b;
    assign cin1   = in_op;
`else
    logic unused_op;
    assign unused_op = ^{in_op, s1.op};
    assign op_sub    = OP_ADD;
    assign b_eff     = in_b;
    assign cin1      = 1'b0;
`endif

    rc_adder #(.N(W)) u_s1_add (
        .a    (in_a),
        .b    (b_eff),
        .cin  (cin1),
        .sum  (sum1),
        .cout (cout1)
    );

    // ADD: raw >= Q iff raw overflowed W bits or raw[W-1:0] - Q carries out
`ifdef MOD_ADD_SUB_SUB_EN
    assign addend = (s1.op == OP_SUB) ? QV : NEG_Q;
    assign take   = (s1.op == OP_SUB) ? ~s1.raw[W]
                                      : (s1.raw[W] | cout2);
`else
    assign addend = NEG_Q;
    assign take   = s1.raw[W] | cout2;
`endif

    rc_adder #(.N(W)) u_s2_corr (
        .a    (s1.raw[W-1:0]),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum2),
        .cout (cout2)
    );

    assign r_next = take ? sum2 : s1.raw[W-1:0];

    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s2_load;
    assign s1_load  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            s1       <= '{op: op_sub, raw: {cout1, sum1}, tag: in_tag};
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_r     <= '0;
            out_tag   <= '0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            out_r     <= r_next;
            out_tag   <= s1.tag;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mod_add_sub.sv
// Directed vector table plus stall, reset and random streaming checks for mod_add_sub.
module tb_mod_add_sub;

    localparam int W = 14;
    localparam int Q = 12289;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             in_op;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_r;
    logic [TAG_W-1:0] out_tag;

    int total = 0;
    int bad = 0;

    mod_add_sub dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit      op;
        int      a;
        int      b;
        int      r_en;
        int      r_dis;
    } vec_t;

    typedef struct {
        int r;
        int tag;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic int ref_model(input bit op, input int a, input int b);
        int r;
`ifdef MOD_ADD_SUB_SUB_EN
        if (op) r = (a - b + Q) % Q;
        else    r = (a + b) % Q;
`else
        r = (a + b) % Q;
`endif
        return r;
    endfunction

    task automatic one_vec(input vec_t v, input int tag);
        int req;
`ifdef MOD_ADD_SUB_SUB_EN
        req = v.r_en;
`else
        req = v.r_dis;
`endif
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = v.op;
        in_a      = W'(v.a);
        in_b      = W'(v.b);
        in_tag    = TAG_W'(tag);
        #1;
        check("vec_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("vec_lat1_valid", int'(out_valid), 0);
        @(negedge clk);
        check("vec_lat2_valid", int'(out_valid), 1);
        check($sformatf("vec_r %0d%s%0d", v.a, v.op ? "-" : "+", v.b),
              int'(out_r), req);
        check("vec_tag", int'(out_tag), tag);
    endtask

    task automatic run_stream(input int n, input bit rnd);
        int sent = 0;
        int cyc = 0;
        bit held = 0;
        int hr = 0;
        int ht = 0;
        bit in_fire;
        bit out_fire;
        exp_t e;
        exp_q.delete();
        while ((sent < n || exp_q.size() != 0) && cyc < n * 20 + 50) begin
            @(negedge clk);
            if (held) begin
                check("stall_valid", int'(out_valid), 1);
                check("stall_r", int'(out_r), hr);
                check("stall_tag", int'(out_tag), ht);
            end
            out_ready = rnd ? ($urandom_range(0, 3) != 0)
                            : !(cyc >= 3 && cyc <= 5);
            if (!in_valid && sent < n && (!rnd || $urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1;
                in_op    = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                in_a     = W'($urandom_range(0, Q - 1));
                in_b     = W'($urandom_range(0, Q - 1));
                in_tag   = TAG_W'(sent);
            end
            #1;
            if (exp_q.size() == 2 && !out_ready)
                check("full_in_ready", int'(in_ready), 0);
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            if (out_fire) begin
                if (exp_q.size() == 0) begin
                    check("stream_spurious", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_r", int'(out_r), e.r);
                    check("stream_tag", int'(out_tag), e.tag);
                end
            end
            held = out_valid && !out_ready;
            hr = int'(out_r);
            ht = int'(out_tag);
            if (in_fire) begin
                e.r   = ref_model(in_op, int'(in_a), int'(in_b));
                e.tag = int'(in_tag);
                exp_q.push_back(e);
                sent++;
            end
            @(posedge clk);
            #1;
            if (in_fire) in_valid = 1'b0;
            cyc++;
        end
        check("stream_sent", sent, n);
        check("stream_drained", exp_q.size(), 0);
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{0, 6000, 7000, 711, 711};
        vecs[1]  = '{0, 12288, 1, 0, 0};
        vecs[2]  = '{0, 12288, 12288, 12287, 12287};
        vecs[3]  = '{0, 0, 0, 0, 0};
        vecs[4]  = '{1, 10, 5, 5, 15};
        vecs[5]  = '{1, 5, 10, 12284, 15};
        vecs[6]  = '{1, 0, 12288, 1, 12288};
        vecs[7]  = '{1, 7, 7, 0, 14};
        vecs[8]  = '{0, 6144, 6145, 0, 0};
        vecs[9]  = '{0, 6144, 6144, 12288, 12288};
        vecs[10] = '{1, 12288, 0, 12288, 12288};
        vecs[11] = '{1, 1, 12288, 2, 0};

        rst = 1'b1;
        in_valid = 1'b0;
        in_op = 1'b0;
        in_a = '0;
        in_b = '0;
        in_tag = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_r", int'(out_r), 0);
        check("rst_out_tag", int'(out_tag), 0);

        for (int i = 0; i < 12; i++)
            one_vec(vecs[i], (i + 3) % 16);

        run_stream(8, 1'b0);

        // fill both stages under stall, then reset
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_op = 1'b0;
        in_a = W'(100);
        in_b = W'(200);
        in_tag = 4'd9;
        @(posedge clk);
        @(negedge clk);
        in_a = W'(300);
        in_tag = 4'd10;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("full_before_rst", int'(in_ready), 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst2_out_valid", int'(out_valid), 0);
        check("rst2_in_ready", int'(in_ready), 1);
        check("rst2_out_r", int'(out_r), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst2_no_stale", int'(out_valid), 0);
        end

        run_stream(10000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
